// File: rtl/switches_debounce_leds.sv
// N-channel switch front end: 2-flop sync, per-channel stability debounce, follow/toggle LED drive, rise/fall strobes.
// Latency: a clean input change reaches o_led/o_rise/o_fall DEBOUNCE_CYCLES+2 edges after it is first sampled; no backpressure.
module switches_debounce_leds #(
    parameter int N               = 7,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_switch,
    input  logic         i_mode,
    output logic [N-1:0] o_led,
    output logic [N-1:0] o_rise,
    output logic [N-1:0] o_fall
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [N-1:0]  stable_q, stable_d;
    logic [N-1:0]  toggle_q, toggle_d;
    logic [N-1:0]  led_q, led_d;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;
    logic [N-1:0]  accept;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    always_comb begin
        sync1_d  = i_switch;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        accept   = '0;
        for (int k = 0; k < N; k++) begin
            cnt_d[k] = '0;
            // Any sample that agrees with the stable level restarts the count.
            if (sync2_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    accept[k]   = 1'b1;
                    stable_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
        rise_d   = accept & sync2_q;
        fall_d   = accept & ~sync2_q;
        // In follow mode the toggle register shadows the debounced level so a
        // switch into toggle mode starts from whatever the LED already shows.
        toggle_d = i_mode ? (toggle_q ^ rise_d) : stable_d;
        led_d    = i_mode ? toggle_d : stable_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            toggle_q <= '0;
            led_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            toggle_q <= toggle_d;
            led_q    <= led_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign o_led  = led_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule
